sha_pipe_stage_bank: RTL

Parametrised multi-channel pipeline register bank for the SHA-256 datapath: carries NCH data words of WIDTH bits plus a SIDEW-bit sideband (mux selects, control flags) through DEPTH register stages. Each stage has a valid bit, and a valid/ready handshake gives back-pressure. This replaces the fixed single-stage 32-bit registers that load on `start`. The bank sits between the message schedule / compression round logic and downstream consumers. Stalled stages retain their contents, empty stages absorb bubbles, and a synchronous flush discards in-flight data.

---
 rtl/sha_pipe_stage_bank.sv | 119 +++++++++++
 1 files changed

// File: rtl/sha_pipe_stage_bank.sv
// sha_pipe_stage_bank
// Multi-channel pipeline register bank for the SHA-256 datapath. Carries
// NCH data words of WIDTH bits plus a SIDEW-bit sideband through DEPTH
// register stages. Each stage has its own valid bit. A combinational
// ready chain lets stalled stages hold their contents while empty stages
// downstream of a new word still absorb it, so bubbles collapse.
// A synchronous flush discards everything in flight.
module sha_pipe_stage_bank #(
    parameter int WIDTH = 32,
    parameter int NCH   = 3,
    parameter int SIDEW = 1,
    parameter int DEPTH = 2,
    localparam int OW   = $clog2(DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [SIDEW-1:0]     in_side,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [SIDEW-1:0]     out_side,
    output logic [OW-1:0]        occupancy
);

    localparam int DW = NCH * WIDTH;

    // Stage 0 is the input stage, stage DEPTH-1 drives the outputs.
    logic [DEPTH-1:0]                v_q, v_d;
    logic [DEPTH-1:0][DW-1:0]        data_q, data_d;
    logic [DEPTH-1:0][SIDEW-1:0]     side_q, side_d;

    // rdy[i]: stage i may load this cycle; rdy[DEPTH] is the downstream.
    logic [DEPTH:0]                  rdy;
    logic                            push;
    logic [OW-1:0]                   occ;

    // Ready chain: a stage can load if it is empty or its successor can load.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v_q[i] || rdy[i+1];
        end
    end

    // The flush cycle never accepts input; the head may still be taken.
    assign in_ready = rdy[0] && !flush;
    assign push     = in_valid && in_ready;

    // Next-state: advance stages that are ready, hold stalled ones.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        v_d    = v_q;
        data_d = data_q;
        side_d = side_q;
        if (flush) begin
            v_d    = '0;
            data_d = '0;
            side_d = '0;
        end else begin
            // Stage 0: a ready stage either takes the new word or becomes
            // empty (it was empty already or has just handed off).
            if (rdy[0]) begin
                v_d[0] = push;
                if (push) begin
                    data_d[0] = in_data;
                    side_d[0] = in_side;
                end
            end
            // Later stages copy their predecessor; a bubble moves only the
            // valid bit so the data registers keep their last word.
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                        side_d[i] = side_q[i-1];
                    end
                end
            end
        end
    end

    // Stage registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // stage samples the pre-edge value of its predecessor.
        if (RST) begin
            // NOTE: the data registers are reset too, because the outputs
            // must read zero while the bank is empty after reset.
            v_q    <= '0;
            data_q <= '0;
            side_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            side_q <= side_d;
        end
    end

    // Occupancy is the population count of the registered valid bits.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OW'(v_q[i]);
        end
    end

    assign occupancy = occ;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_side  = side_q[DEPTH-1];

endmodule
